// File: rtl/vga_fb_arbiter_if.sv
// Signal bundle between the framebuffer arbiter and its display, writer and RAM neighbours.
// The arbiter takes the slave view; the environment (timing logic, writer, RAM) takes master.
interface vga_fb_arbiter_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 16
);
  logic              frame_start;
  logic              pix_pop;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              underflow;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  frame_start, pix_pop, wr_valid, wr_addr, wr_data, ram_rdata,
    output pix_data, pix_valid, underflow, wr_ready, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output frame_start, pix_pop, wr_valid, wr_addr, wr_data, ram_rdata,
    input  pix_data, pix_valid, underflow, wr_ready, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port synchronous framebuffer RAM between display prefetch and a pixel writer.
// Fetch has strict priority until the prefetch FIFO (plus reads in flight) reaches HIGH_WM.
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FB_WORDS   = 76800,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned HIGH_WM    = 6
) (
  input logic            clk,
  input logic            reset,
  vga_fb_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic              r_rd1;        // read presented on the RAM bus this cycle
  logic              r_rd2;        // read data on ram_rdata this cycle
  logic              r_underflow;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;

  logic [CW-1:0] w_occ;
  logic          w_pix_valid;
  logic          w_fetch_ok;
  logic          w_wr_ready;
  logic          w_wr_go;
  logic          w_wr_keep;
  logic          w_fetch_go;
  logic          w_push;
  logic          w_pop;

  assign w_occ       = r_count + CW'(r_rd1) + CW'(r_rd2);
  assign w_pix_valid = (r_count != '0);
  assign w_fetch_ok  = (r_fetch_addr < ADDR_W'(FB_WORDS)) && (w_occ < CW'(FIFO_DEPTH)) &&
                       !bus.frame_start;
  assign w_wr_ready  = !((w_occ < CW'(HIGH_WM)) && w_fetch_ok);
  assign w_wr_go     = bus.wr_valid && w_wr_ready;
  // Out-of-range writes complete the handshake but never reach the RAM.
  assign w_wr_keep   = w_wr_go && (bus.wr_addr < ADDR_W'(FB_WORDS));
  assign w_fetch_go  = w_fetch_ok && !w_wr_go;
  // A flush discards the returning read and any pop in the same cycle.
  assign w_push      = r_rd2 && !bus.frame_start;
  assign w_pop       = bus.pix_pop && w_pix_valid && !bus.frame_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_fetch_addr <= '0;
      r_rd1        <= 1'b0;
      r_rd2        <= 1'b0;
      r_underflow  <= 1'b0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
    end else begin
      r_rd1 <= w_fetch_go;
      r_rd2 <= r_rd1 && !bus.frame_start;

      if (bus.frame_start) begin
        r_fetch_addr <= '0;
        r_wptr       <= '0;
        r_rptr       <= '0;
        r_count      <= '0;
      end else begin
        if (w_fetch_go) r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
        if (w_push) begin
          r_mem[r_wptr] <= bus.ram_rdata;
          r_wptr        <= r_wptr + PW'(1);
        end
        if (w_pop) r_rptr <= r_rptr + PW'(1);
        if (w_push && !w_pop) r_count <= r_count + CW'(1);
        else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end

      if (bus.pix_pop && !w_pix_valid) r_underflow <= 1'b1;

      r_ram_en <= w_fetch_go || w_wr_keep;
      r_ram_we <= w_wr_keep;
      if (w_fetch_go) begin
        r_ram_addr <= r_fetch_addr;
      end else if (w_wr_keep) begin
        r_ram_addr  <= bus.wr_addr;
        r_ram_wdata <= bus.wr_data;
      end
    end
  end

  assign bus.pix_data  = r_mem[r_rptr];
  assign bus.pix_valid = w_pix_valid;
  assign bus.underflow = r_underflow;
  assign bus.wr_ready  = w_wr_ready;
  assign bus.ram_en    = r_ram_en;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: a frame-level reference (expected pixel stream, write
// log, occupancy from issued-minus-popped counts) is checked by a negedge monitor.
module tb_vga_fb_arbiter;
  localparam int unsigned ADDR_W     = 17;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FB_WORDS   = 76800;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned HIGH_WM    = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_WORDS(FB_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH), .HIGH_WM(HIGH_WM)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Framebuffer RAM: word k holds k until written.
  bit          ram_wr  [FB_WORDS];
  logic [15:0] ram_val [FB_WORDS];
  always @(posedge clk) begin
    if (bus.ram_en && int'(bus.ram_addr) < FB_WORDS) begin
      if (bus.ram_we) begin
        ram_val[bus.ram_addr] <= bus.ram_wdata;
        ram_wr[bus.ram_addr]  <= 1'b1;
      end else begin
        bus.ram_rdata <= ram_wr[bus.ram_addr] ? ram_val[bus.ram_addr] : 16'(bus.ram_addr);
      end
    end
  end

  // Reference framebuffer contents as seen by accepted writes.
  bit          ref_wr  [FB_WORDS];
  logic [15:0] ref_val [FB_WORDS];
  function automatic logic [15:0] ref_word(input int k);
    return ref_wr[k] ? ref_val[k] : 16'(k);
  endfunction

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_pix [$];
  logic [ADDR_W+DATA_W-1:0] wq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: DUT output with no expected entry (t=%0t)", name, $time);
  endtask

  // Monitor: RAM bus, arbitration rule, write log and pixel stream.
  int m_issued = 0;
  int m_popped = 0;
  int m_fetch_next = 0;
  initial begin
    int  occ;
    bit  fok;
    logic [ADDR_W+DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_issued = 0; m_popped = 0; m_fetch_next = 0;
        wq.delete();
      end else begin
        if (bus.ram_en && bus.ram_we) begin
          if (wq.size() == 0) fail_now("ram_write");
          else begin
            e = wq.pop_front();
            chk("ram_waddr", 32'(bus.ram_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
            chk("ram_wdata", 32'(bus.ram_wdata), 32'(e[DATA_W-1:0]));
          end
        end else if (bus.ram_en) begin
          chk("fetch_addr", 32'(bus.ram_addr), 32'(m_fetch_next));
          m_fetch_next++;
          m_issued++;
        end
        occ = m_issued - m_popped;
        chk("occ_bound", 32'(occ <= int'(FIFO_DEPTH)), 32'd1);
        fok = (m_fetch_next < int'(FB_WORDS)) && (occ < int'(FIFO_DEPTH)) && !bus.frame_start;
        chk("wr_ready", 32'(bus.wr_ready), 32'(!((occ < int'(HIGH_WM)) && fok)));
        if (bus.wr_valid && bus.wr_ready && int'(bus.wr_addr) < FB_WORDS) begin
          ref_val[bus.wr_addr] = bus.wr_data;
          ref_wr[bus.wr_addr]  = 1'b1;
          wq.push_back({bus.wr_addr, bus.wr_data});
        end
        if (bus.pix_pop && bus.pix_valid && !bus.frame_start) begin
          if (exp_pix.size() == 0) fail_now("pix_data");
          else chk("pix_data", 32'(bus.pix_data), 32'(exp_pix.pop_front()));
          m_popped++;
        end
        if (bus.frame_start) begin
          m_issued = 0; m_popped = 0; m_fetch_next = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Call at a cycle start; returns at the start of the cycle after the pulse.
  task automatic start_frame(input int n);
    exp_pix.delete();
    for (int k = 0; k < n; k++) exp_pix.push_back(ref_word(k));
    bus.frame_start = 1'b1;
    cyc();
    bus.frame_start = 1'b0;
  endtask

  task automatic pop_n(input int budget);
    int k = 0;
    while (exp_pix.size() > 0 && k < budget) begin
      bus.pix_pop = bus.pix_valid;
      cyc();
      k++;
    end
    bus.pix_pop = 1'b0;
    chk("drain", 32'(exp_pix.size()), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pix_data"},  32'(bus.pix_data), 32'd0);
    chk({tag, "_pix_valid"}, 32'(bus.pix_valid), 32'd0);
    chk({tag, "_underflow"}, 32'(bus.underflow), 32'd0);
    chk({tag, "_wr_ready"},  32'(bus.wr_ready), 32'd0);
    chk({tag, "_ram_en"},    32'(bus.ram_en), 32'd0);
    chk({tag, "_ram_we"},    32'(bus.ram_we), 32'd0);
    chk({tag, "_ram_addr"},  32'(bus.ram_addr), 32'd0);
    chk({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 32'd0);
  endtask

  initial begin
    int  wi;
    bit  pend;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    bus.frame_start = 1'b0;
    bus.pix_pop     = 1'b0;
    bus.wr_valid    = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");

    // Fill after frame_start: eight back-to-back reads, first pixel three cycles after issue.
    cyc();
    reset = 1'b0;
    start_frame(256);
    @(negedge clk);
    chk("t1_c1_ram_en", 32'(bus.ram_en), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      @(negedge clk);
      chk("t1_ram_en", 32'(bus.ram_en), 32'd1);
      chk("t1_ram_we", 32'(bus.ram_we), 32'd0);
      chk("t1_ram_addr", 32'(bus.ram_addr), 32'(i));
      chk("t1_pix_valid", 32'(bus.pix_valid), 32'(i >= 2));
    end
    cyc();
    @(negedge clk);
    chk("t1_stop", 32'(bus.ram_en), 32'd0);
    chk("t1_head", 32'(bus.pix_data), 32'd0);

    // Pop every 4th cycle with a writer streaming to 100+i.
    wi = 0;
    rd = 16'($urandom);
    for (int i = 0; i < 160; i++) begin
      cyc();
      bus.pix_pop  = (i % 4 == 3);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = ADDR_W'(100 + wi);
      bus.wr_data  = rd;
      @(negedge clk);
      if (bus.wr_ready) begin
        wi++;
        rd = 16'($urandom);
      end
    end
    cyc();
    bus.pix_pop  = 1'b0;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("t2_underflow", 32'(bus.underflow), 32'd0);
    chk("t2_writes_progress", 32'(wi > 20), 32'd1);

    // Single write to word 5, visible as the 6th pixel of the next frame.
    repeat (12) cyc();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = ADDR_W'(5);
    bus.wr_data  = 16'hF800;
    @(negedge clk);
    chk("t3_wr_ready", 32'(bus.wr_ready), 32'd1);
    cyc();
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("t3_ram_en", 32'(bus.ram_en), 32'd1);
    chk("t3_ram_we", 32'(bus.ram_we), 32'd1);
    chk("t3_ram_addr", 32'(bus.ram_addr), 32'd5);
    chk("t3_ram_wdata", 32'(bus.ram_wdata), 32'hF800);
    cyc();
    start_frame(16);
    pop_n(200);

    // frame_start while two reads are in flight: both are discarded.
    start_frame(0);
    cyc();
    cyc();
    start_frame(8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_pix_valid", 32'(bus.pix_valid), 32'(i == 3));
      if (i == 3) chk("t4_first_pix", 32'(bus.pix_data), 32'(ref_word(0)));
      cyc();
    end
    pop_n(100);

    // Underflow is sticky across frame_start.
    start_frame(0);
    bus.pix_pop = 1'b1;
    @(negedge clk);
    chk("t5_empty", 32'(bus.pix_valid), 32'd0);
    cyc();
    bus.pix_pop = 1'b0;
    @(negedge clk);
    chk("t5_underflow_set", 32'(bus.underflow), 32'd1);
    cyc();
    start_frame(0);
    @(negedge clk);
    chk("t5_underflow_sticky", 32'(bus.underflow), 32'd1);
    cyc();

    // Random pops and writes (to 400..599 or out of range), two frames.
    pend = 1'b0;
    ra = '0;
    rd = '0;
    for (int i = 0; i < 300; i++) begin
      if (i == 0 || i == 150) begin
        exp_pix.delete();
        for (int k = 0; k < 300; k++) exp_pix.push_back(ref_word(k));
        bus.frame_start = 1'b1;
      end else begin
        bus.frame_start = 1'b0;
      end
      bus.pix_pop = 1'($urandom_range(1, 0));
      if (!pend) begin
        pend = 1'($urandom_range(1, 0));
        ra = ($urandom_range(7, 0) == 0) ? ADDR_W'(FB_WORDS + $urandom_range(999, 0))
                                         : ADDR_W'(400 + $urandom_range(199, 0));
        rd = 16'($urandom);
      end
      bus.wr_valid = pend;
      bus.wr_addr  = ra;
      bus.wr_data  = rd;
      @(negedge clk);
      if (pend && bus.wr_ready) pend = 1'b0;
      cyc();
    end
    bus.frame_start = 1'b0;
    bus.pix_pop     = 1'b0;
    bus.wr_valid    = 1'b0;
    start_frame(700);
    pop_n(2000);

    // Out-of-range write is accepted and dropped.
    repeat (12) cyc();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = ADDR_W'(FB_WORDS);
    bus.wr_data  = 16'h1234;
    @(negedge clk);
    chk("t6_drop_ready", 32'(bus.wr_ready), 32'd1);
    cyc();
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("t6_drop_ram_en", 32'(bus.ram_en), 32'd0);

    // Reset in the middle of a fetch, then restart at word 0.
    cyc();
    start_frame(8);
    cyc();
    reset = 1'b1;
    #1;
    chk_idle_outputs("midreset");
    cyc();
    reset = 1'b0;
    start_frame(8);
    @(negedge clk);
    chk("t6_restart_idle", 32'(bus.ram_en), 32'd0);
    cyc();
    @(negedge clk);
    chk("t6_restart_en", 32'(bus.ram_en), 32'd1);
    chk("t6_restart_addr", 32'(bus.ram_addr), 32'd0);
    cyc();
    pop_n(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port, synchronous-read framebuffer RAM between the VGA display fetch path and a pixel writer (draw engine or CPU bridge).
- Keeps an internal pixel prefetch FIFO topped up so the display side never starves.
- Grants remaining RAM slots to the writer through a valid/ready handshake.
- Sits between the clock divider / VGA timing logic and the framebuffer RAM, in the 100 MHz domain; the display consumes pixels via a pop strobe.

Parameters:
- ADDR_W, 17, framebuffer word-address width.
- DATA_W, 16, pixel width (RGB565, matching the 5/6/5 VGA outputs).
- FB_WORDS, 76800, number of pixels per frame (320x240); the fetch stops at this count.
- FIFO_DEPTH, 8, prefetch FIFO entries (power of two).
- HIGH_WM, 6, occupancy below which fetch has strict priority over writes.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse during vertical blanking; restarts fetch at word 0.
- pix_pop  in  1  display consumes the head pixel this cycle.
- pix_data  out  DATA_W  head-of-FIFO pixel; valid when pix_valid=1.
- pix_valid  out  1  FIFO non-empty.
- underflow  out  1  sticky: pix_pop seen while pix_valid=0.
- wr_valid  in  1  writer request.
- wr_ready  out  1  writer slot available.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write pixel.
- ram_en  out  1  RAM access enable (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_wdata  out  DATA_W  RAM write data (registered).
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read is presented on ram_*.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high.
- Reset state: all outputs 0, fifo empty, fetch_addr=0, in-flight=0, fetch enabled.
- Occupancy: occ = fifo_count + reads in flight (issued, not yet pushed). occ never exceeds FIFO_DEPTH.
- Fetch eligibility: fetch_ok = (fetch_addr < FB_WORDS) & (occ < FIFO_DEPTH) & ~frame_start.
- Per-cycle arbitration, one RAM access per cycle:
  - occ < HIGH_WM and fetch_ok: fetch wins. wr_ready=0.
  - HIGH_WM <= occ < FIFO_DEPTH: wr_ready=1. A write happens if wr_valid; otherwise a fetch happens if fetch_ok.
  - occ = FIFO_DEPTH, or fetch_addr = FB_WORDS: wr_ready=1; fetch idle.
  - wr_ready never depends on wr_valid.
- Fetch issue (cycle N): registers ram_en=1, ram_we=0, ram_addr=fetch_addr at N+1. fetch_addr increments; in-flight increments.
- Read return: ram_rdata is sampled at N+2 and pushed into the FIFO. pix_valid rises at N+3 for the first pixel after empty, so fetch-to-display latency is 3 cycles.
- Write accept (wr_valid & wr_ready in cycle N): ram_en=1, ram_we=1, ram_addr/ram_wdata = captured values at N+1.
  - If wr_addr >= FB_WORDS, the handshake still completes but ram_en stays 0 (write dropped).
- Idle cycles: ram_en=0, ram_we=0; ram_addr and ram_wdata hold their last values.
- Pop: pix_pop & pix_valid removes the head. Push and pop in the same cycle leave the count unchanged.
  - pix_pop with pix_valid=0 sets underflow, leaves the FIFO unchanged, and does not change pix_data.
- underflow: cleared only by reset.
- frame_start (any cycle):
  - next cycle: fifo_count=0, fetch_addr=0.
  - Reads still in flight are tagged stale and discarded on return; they are not pushed and do not count toward occ afterwards.
  - A pop in the same cycle is ignored (flush wins).
  - A write accepted in the same cycle still completes.
- Fetch does not wrap at FB_WORDS; it resumes only after frame_start.
- Reset mid-operation: the RAM access in progress is abandoned (ram_en=0 immediately); no write is re-issued.

Test Plan:
- Reset, then frame_start, wr_valid=0: ram_addr steps 0..7 on 8 consecutive cycles with ram_we=0; pix_valid=1 three cycles after the first issue; fetch stops at occ=8; pix_data=word 0.
- Preload RAM word k = k. Pop every 4th cycle with wr_valid held high at addresses 100+i: pixels 0,1,2,... arrive in order; underflow stays 0; writes progress only while occ>=6.
- Write addr 5 data 0xF800 (handshake completes in 1 cycle, ram_we pulse at addr 5), then frame_start: the 6th popped pixel = 0xF800.
- frame_start issued 1 cycle after two reads were issued: FIFO empty next cycle; both stale returns are discarded; the first pixel afterwards is word 0.
- pix_pop with FIFO empty: underflow=1; it stays 1 across frame_start; it clears only on reset.
- Write to addr 76800: wr_ready & wr_valid complete, ram_en stays 0. Assert reset mid-fetch: all outputs 0 immediately; after release plus frame_start, the fetch restarts at 0.
